// File: rtl/idma_axis_accel_pkg.sv
// rtl/idma_axis_accel_pkg.sv - shared types, default stream structs and the per-beat data operation
package idma_axis_accel_pkg;

  localparam int CntWidth     = 32;
  localparam int MaxDataWidth = 512;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    XOR  = 2'd2,
    INV  = 2'd3
  } op_e;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic [7:0]  tkeep;
    logic        tlast;
    logic [2:0]  tid;
    logic [0:0]  tdest;
    logic [0:0]  tuser;
  } default_axis_t_chan_t;

  typedef struct packed {
    default_axis_t_chan_t t;
    logic                 tvalid;
  } default_axis_req_t;

  typedef struct packed {
    logic tready;
  } default_axis_rsp_t;

  // Callers zero-extend to MaxDataWidth and truncate the result, which keeps ADD modulo 2^DataWidth.
  function automatic logic [MaxDataWidth-1:0] apply_op(
    input op_e                     op,
    input logic [MaxDataWidth-1:0] data,
    input logic [MaxDataWidth-1:0] operand
  );
    logic [MaxDataWidth-1:0] res;
    unique case (op)
      ADD:     res = data + operand;
      XOR:     res = data ^ operand;
      INV:     res = ~data;
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/idma_axis_accel_fifo.sv
// rtl/idma_axis_accel_fifo.sv - synchronous FIFO of stream beats with wrap-bit pointers
module idma_axis_accel_fifo #(
  parameter int  Depth = 8,
  parameter type T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   usage
);

  localparam int AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] PtrOne  = (AddrWidth+1)'(1);
  localparam logic [AddrWidth:0] FullXor = {1'b1, {AddrWidth{1'b0}}};

  logic [AddrWidth:0] wr_ptr, rd_ptr;
  T mem [Depth];

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AddrWidth-1:0]] <= wdata;
  end

  assign full  = (wr_ptr ^ rd_ptr) == FullXor;
  assign empty = wr_ptr == rd_ptr;
  assign usage = wr_ptr - rd_ptr;
  // Stale storage is never exposed, so a flushed FIFO presents an all-zero payload.
  assign rdata = empty ? T'('0) : mem[rd_ptr[AddrWidth-1:0]];

endmodule

// File: rtl/idma_axis_accel_endpoint.sv
// rtl/idma_axis_accel_endpoint.sv - stream loopback endpoint with per-beat op; IDMA_AXIS_ACCEL_STATS_EN adds beat/peak-fill stats
module idma_axis_accel_endpoint
  import idma_axis_accel_pkg::*;
#(
  parameter int  DataWidth     = 64,
  parameter int  StrbWidth     = 8,
  parameter int  IdWidth       = 3,
  parameter int  DestWidth     = 1,
  parameter int  UserWidth     = 1,
  parameter int  Depth         = 8,
  parameter type axis_req_t    = default_axis_req_t,
  parameter type axis_rsp_t    = default_axis_rsp_t,
  parameter type axis_t_chan_t = default_axis_t_chan_t
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  axis_req_t                s_axis_req_i,
  output axis_rsp_t                s_axis_rsp_o,
  output axis_req_t                m_axis_req_o,
  input  axis_rsp_t                m_axis_rsp_i,
  input  logic [1:0]               op_i,
  input  logic [DataWidth-1:0]     operand_i,
  output logic [CntWidth-1:0]      pkt_cnt_o,
  output logic                     busy_o,
  output logic [CntWidth-1:0]      beat_cnt_o,
  output logic [$clog2(Depth):0]   max_fill_o
);

  localparam int AddrWidth = $clog2(Depth);

  if ($bits(axis_t_chan_t) != DataWidth + 2*StrbWidth + IdWidth + DestWidth + UserWidth + 1)
  begin : g_bad_chan
    $error("axis_t_chan_t does not match the configured field widths");
  end
  if (Depth < 2 || (1 << AddrWidth) != Depth) begin : g_bad_depth
    $error("Depth must be a power of two and at least 2");
  end

  logic                 full, empty, s_ready, push, pop;
  logic [AddrWidth:0]   usage;
  logic [DataWidth-1:0] op_res;
  axis_t_chan_t         enq_chan, head_chan;
  logic [CntWidth-1:0]  pkt_cnt_q;

  // Ready is held low while reset is asserted and rises as soon as it is released.
  assign s_ready = !full && !rst;
  assign push    = s_axis_req_i.tvalid && s_ready;
  assign pop     = !empty && m_axis_rsp_i.tready;

  assign op_res = DataWidth'(apply_op(op_e'(op_i),
                                      MaxDataWidth'(s_axis_req_i.t.tdata),
                                      MaxDataWidth'(operand_i)));

  always_comb begin
    enq_chan       = s_axis_req_i.t;
    enq_chan.tdata = op_res;
  end

  idma_axis_accel_fifo #(
    .Depth (Depth),
    .T     (axis_t_chan_t)
  ) i_fifo (
    .clk_i (clk_i),
    .rst   (rst),
    .push  (push),
    .wdata (enq_chan),
    .pop   (pop),
    .rdata (head_chan),
    .full  (full),
    .empty (empty),
    .usage (usage)
  );

  always_comb begin
    s_axis_rsp_o        = '0;
    s_axis_rsp_o.tready = s_ready;
    m_axis_req_o        = '0;
    m_axis_req_o.t      = head_chan;
    m_axis_req_o.tvalid = !empty;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (pop && head_chan.tlast) begin
      pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign busy_o    = usage != '0;

`ifdef IDMA_AXIS_ACCEL_STATS_EN
  logic [CntWidth-1:0] beat_cnt_q;
  logic [AddrWidth:0]  max_fill_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      max_fill_q <= '0;
    end else begin
      if (push)               beat_cnt_q <= beat_cnt_q + CntWidth'(1);
      if (usage > max_fill_q) max_fill_q <= usage;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
  assign max_fill_o = max_fill_q;
`else
  assign beat_cnt_o = '0;
  assign max_fill_o = '0;
`endif

endmodule

// File: tb/tb_idma_axis_accel_endpoint.sv
// tb/tb_idma_axis_accel_endpoint.sv - directed self-checking bench for idma_axis_accel_endpoint
module tb_idma_axis_accel_endpoint;
  import idma_axis_accel_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst   = 1'b1;
  default_axis_req_t    s_req;
  default_axis_rsp_t    s_rsp;
  default_axis_req_t    m_req;
  default_axis_rsp_t    m_rsp;
  logic [1:0]           op;
  logic [63:0]          operand;
  logic [31:0]          pkt_cnt, beat_cnt;
  logic                 busy;
  logic [3:0]           max_fill;

  int checks   = 0;
  int failures = 0;
  logic [63:0] out_data [$];
  logic        out_last [$];
  logic [63:0] exp_q    [$];

  always #5 clk_i = ~clk_i;

  idma_axis_accel_endpoint dut (
    .clk_i        (clk_i),
    .rst          (rst),
    .s_axis_req_i (s_req),
    .s_axis_rsp_o (s_rsp),
    .m_axis_req_o (m_req),
    .m_axis_rsp_i (m_rsp),
    .op_i         (op),
    .operand_i    (operand),
    .pkt_cnt_o    (pkt_cnt),
    .busy_o       (busy),
    .beat_cnt_o   (beat_cnt),
    .max_fill_o   (max_fill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst && m_req.tvalid && m_rsp.tready) begin
      out_data.push_back(m_req.t.tdata);
      out_last.push_back(m_req.t.tlast);
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    s_req.t.tdata = d;
    s_req.t.tlast = last;
    s_req.t.tstrb = 8'hFF;
    s_req.t.tkeep = 8'hFF;
    s_req.tvalid  = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      acc = s_rsp.tready;
      @(posedge clk_i);
      #1;
      if (acc) break;
    end
    s_req.tvalid = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && busy; n++) begin
      @(posedge clk_i);
      #1;
    end
    check("drain_busy_low", busy, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_stream(input string tag, input int last_idx);
    check({tag, "_count"}, out_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), out_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), out_last[i], (i == last_idx));
    end
    out_data.delete();
    out_last.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    s_req        = '0;
    m_rsp.tready = 1'b0;
    op           = 2'd0;
    operand      = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_s_tready", s_rsp.tready, 1'b0);
    check("rst_m_tvalid", m_req.tvalid, 1'b0);
    check("rst_m_tdata", m_req.t.tdata, 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_beat_cnt", beat_cnt, 32'd0);
    check("rst_max_fill", max_fill, 4'd0);
    rst = 1'b0;
    #1;
    check("post_rst_s_tready", s_rsp.tready, 1'b1);

    // PASS, 16 beats, one-cycle latency on the first beat
    m_rsp.tready = 1'b1;
    op = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      send_beat(64'(i), i == 16);
      if (i == 1) begin
        check("lat_m_tvalid", m_req.tvalid, 1'b1);
        check("lat_m_tdata", m_req.t.tdata, 64'd1);
      end
      exp_q.push_back(64'(i));
    end
    drain();
    check_stream("pass", 15);
    check("pass_pkt_cnt", pkt_cnt, 32'd1);

    // ADD with carry dropped
    op = 2'd1;
    operand = 64'h100;
    send_beat(64'h1, 1'b0);
    send_beat(64'h2, 1'b0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    exp_q = '{64'h101, 64'h102, 64'hFF};
    drain();
    check_stream("add", 2);
    check("add_pkt_cnt", pkt_cnt, 32'd2);

    // XOR then INV; op changes while the first result sits in the FIFO
    m_rsp.tready = 1'b0;
    op = 2'd2;
    operand = 64'hFFFF_FFFF_FFFF_FFFF;
    send_beat(64'h0123_4567_89AB_CDEF, 1'b1);
    op = 2'd3;
    operand = 64'h0;
    send_beat(64'h0123_4567_89AB_CDEF, 1'b1);
    op = 2'd0;
    check("xor_hold_tdata", m_req.t.tdata, 64'hFEDC_BA98_7654_3210);
    m_rsp.tready = 1'b1;
    exp_q = '{64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
    drain();
    out_last.delete();
    out_last = '{1'b1, 1'b1};
    check("xinv_count", out_data.size(), 2);
    for (int i = 0; i < 2 && i < out_data.size(); i++)
      check($sformatf("xinv_data%0d", i), out_data[i], exp_q[i]);
    out_data.delete();
    out_last.delete();
    exp_q.delete();
    check("xinv_pkt_cnt", pkt_cnt, 32'd4);

    // Backpressure: 10 beats offered for 12 cycles into a stalled 8-deep FIFO
    do_reset();
    m_rsp.tready = 1'b0;
    op = 2'd0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      s_req.tvalid  = (k < 10);
      s_req.t.tdata = 64'hA0 + 64'(k);
      s_req.t.tlast = (k == 9);
      @(negedge clk_i);
      if (s_req.tvalid && s_rsp.tready) k++;
      @(posedge clk_i);
      #1;
    end
    s_req.tvalid = 1'b0;
    check("bp_accepted", 64'(k), 64'd8);
    check("bp_s_tready", s_rsp.tready, 1'b0);
    check("bp_busy", busy, 1'b1);
    check("bp_head", m_req.t.tdata, 64'hA0);
`ifdef IDMA_AXIS_ACCEL_STATS_EN
    check("bp_max_fill", max_fill, 4'd8);
`endif
    m_rsp.tready = 1'b1;
    for (int i = k; i < 10; i++) send_beat(64'hA0 + 64'(i), i == 9);
    for (int i = 0; i < 10; i++) exp_q.push_back(64'hA0 + 64'(i));
    drain();
    check_stream("bp", 9);
    check("bp_pkt_cnt", pkt_cnt, 32'd1);
`ifdef IDMA_AXIS_ACCEL_STATS_EN
    check("bp_beat_cnt", beat_cnt, 32'd10);
    check("bp_max_fill_end", max_fill, 4'd8);
`endif

    // Reset with a partial packet buffered
    m_rsp.tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(64'hB0 + 64'(i), 1'b0);
    check("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_req.tvalid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pkt_cnt", pkt_cnt, 32'd0);
    check("mid_rst_s_tready", s_rsp.tready, 1'b0);
    @(posedge clk_i);
    #1;
    rst = 1'b0;
    m_rsp.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(64'hC0 + 64'(i), i == 3);
      exp_q.push_back(64'hC0 + 64'(i));
    end
    drain();
    check_stream("after_rst", 3);
    check("after_rst_pkt_cnt", pkt_cnt, 32'd1);
`ifdef IDMA_AXIS_ACCEL_STATS_EN
    check("after_rst_beat_cnt", beat_cnt, 32'd4);
`else
    check("stats_off_beat_cnt", beat_cnt, 32'd0);
    check("stats_off_max_fill", max_fill, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
